ex_muldiv_ctrl: RTL and testbench

- Multi-cycle sequencer for RV32M multiply/divide in the EX stage.
- Accepts an op from the ID/EX register and stalls IF/ID/EX while iterating a radix-2 shift-add / restoring-divide datapath.
- Delivers one registered result, which EX muxes into the AluOut path.
- Sits beside the single-cycle alu; the hazard unit ORs o_stall into the pipeline freeze.

---
 rtl/ex_muldiv_ctrl_pkg.sv | 35 +++
 rtl/ex_muldiv_ctrl_if.sv | 26 ++
 rtl/ex_muldiv_ctrl_mdu_step.sv | 35 +++
 rtl/ex_muldiv_ctrl.sv | 139 +++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared types for the EX-stage RV32M multiply/divide sequencer.
package ex_muldiv_ctrl_pkg;

  // Encoding follows funct3 so the decoder can pass it straight through.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_a_signed(input mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// Handshake/data bundle between the EX stage and the multiply/divide sequencer.
interface ex_muldiv_ctrl_if
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic             i_flush;
  mdu_op_e          i_op;
  logic [WIDTH-1:0] i_dataA;
  logic [WIDTH-1:0] i_dataB;
  logic             o_stall;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;

  modport master (
    output i_start, i_flush, i_op, i_dataA, i_dataB,
    input  o_stall, o_busy, o_valid, o_result
  );

  modport slave (
    input  i_start, i_flush, i_op, i_dataA, i_dataB,
    output o_stall, o_busy, o_valid, o_result
  );
endinterface

// File: rtl/ex_muldiv_ctrl_mdu_step.sv
// One radix-2 iteration on the {hi, lo} accumulator: shift-add multiply
// (multiplier consumed from lo[0]) or restoring divide (quotient shifted into lo).
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hi_nxt  = hi;
    lo_nxt  = lo;
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    partial = {hi, lo[WIDTH-1]};
    fits    = partial >= {1'b0, operand};
    // When the trial subtract succeeds the remainder is below the divisor,
    // so the low WIDTH bits of the modular difference are exact.
    diff    = partial[WIDTH-1:0] - operand;
    if (is_div) begin
      hi_nxt = fits ? diff : partial[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], fits};
    end else begin
      {hi_nxt, lo_nxt} = {sum, lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage.
// Optional MDU_EARLY_OUT_EN skips iteration when a zero operand fixes the result.
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  ex_muldiv_ctrl_if.slave      bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_CALC  = ST_CALC;
  localparam logic [1:0] S_FIXUP = ST_FIXUP;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  mdu_op_e          op_q;
  logic [WIDTH-1:0] hi_q, lo_q, mag_b_q, a_raw_q, result_q;
  logic             sign_a_q, sign_b_q, b_zero_q, valid_q;

  logic             accept;
  logic             sign_a, sign_b, early;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot, rem, fix_result;

  assign accept = bus.i_start & ~bus.i_flush;

  always_comb begin
    sign_a = op_a_signed(bus.i_op) & bus.i_dataA[WIDTH-1];
    sign_b = op_b_signed(bus.i_op) & bus.i_dataB[WIDTH-1];
    mag_a  = sign_a ? -bus.i_dataA : bus.i_dataA;
    mag_b  = sign_b ? -bus.i_dataB : bus.i_dataB;
  end

`ifdef MDU_EARLY_OUT_EN
  assign early = op_is_div(bus.i_op) ? (bus.i_dataB == '0)
                                     : (bus.i_dataA == '0 || bus.i_dataB == '0);
`else
  assign early = 1'b0;
`endif

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_is_div(op_q)),
    .hi      (hi_q),
    .lo      (lo_q),
    .operand (mag_b_q),
    .hi_nxt  (hi_nxt),
    .lo_nxt  (lo_nxt)
  );

  // Sign correction on the magnitude result; divide-by-zero overrides it.
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    quot     = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    rem      = sign_a_q ? -hi_q : hi_q;
    if (b_zero_q) begin
      quot = '1;
      rem  = a_raw_q;
    end
    case (op_q)
      OP_MUL:                       fix_result = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_result = quot;
      default:                      fix_result = rem;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      // NOTE: all datapath registers are reset too; they are few and plain flops,
      // and a known o_result after reset simplifies pipeline bring-up.
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= OP_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      mag_b_q  <= '0;
      a_raw_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.i_flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.i_start) begin
              op_q     <= bus.i_op;
              sign_a_q <= sign_a;
              sign_b_q <= sign_b;
              mag_b_q  <= mag_b;
              a_raw_q  <= bus.i_dataA;
              b_zero_q <= (bus.i_dataB == '0);
              hi_q     <= '0;
              // A zero multiplier must give a zero product if iteration is skipped.
              lo_q     <= (early && !op_is_div(bus.i_op)) ? '0 : mag_a;
              cnt      <= CW'(WIDTH);
              state    <= early ? S_FIXUP : S_CALC;
            end
          end
          S_CALC: begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            cnt  <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= S_FIXUP;
          end
          S_FIXUP: begin
            result_q <= fix_result;
            valid_q  <= 1'b1;
            state    <= S_DONE;
          end
          // i_start is ignored here: the finished instruction is still in EX.
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_stall  = i_rst & (((state == S_IDLE) & accept) |
                                 (state == S_CALC) | (state == S_FIXUP));
  assign bus.o_busy   = (state != S_IDLE);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: directed RV32M cases plus random ops
// checked against an arithmetic reference model; honours MDU_EARLY_OUT_EN.
module tb_ex_muldiv_ctrl;
  import ex_muldiv_ctrl_pkg::*;

  typedef struct {
    logic [31:0] result;
    int          cyc;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  ex_muldiv_ctrl_if #(.WIDTH(32)) bus ();

  ex_muldiv_ctrl #(.WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input mdu_op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
    int          sa, sb_;
    longint      p;
    logic [63:0] pu;
    sa  = $signed(a);
    sb_ = $signed(b);
    case (op)
      OP_MUL:    return a * b;
      OP_MULH:   begin p = longint'(sa) * longint'(sb_);        return p[63:32]; end
      OP_MULHSU: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
      OP_MULHU:  begin pu = {32'd0, a} * {32'd0, b};            return pu[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb_;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb_;
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input mdu_op_e op, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    logic is_div;
    is_div = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    if (is_div ? (b == 0) : (a == 0 || b == 0)) return 2;
`endif
    return 34;
  endfunction

  // Monitor: every o_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.o_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_sb_depth", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, bus.o_result, e.result);
        check({e.name, "_valid_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called just after a rising edge; leaves i_start low just after the DONE edge.
  task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    int c, k, lat;
    exp_t e;
    lat          = exp_latency(op, a, b);
    bus.i_op     = op;
    bus.i_dataA  = a;
    bus.i_dataB  = b;
    bus.i_start  = 1'b1;
    c            = cyc;
    e.result     = ref_model(op, a, b);
    e.cyc        = c + lat;
    e.name       = name;
    sb.push_back(e);
    k = 0;
    do begin
      @(negedge clk);
      k = cyc - c;
      check({name, "_stall"}, 32'(bus.o_stall), 32'(k < lat));
      if (k >= 1) begin
        // Operands are latched at accept; wiggle them to prove it.
        bus.i_op    = mdu_op_e'($urandom_range(0, 7));
        bus.i_dataA = $urandom;
        bus.i_dataB = $urandom;
      end
    end while (!bus.o_valid && k <= lat + 4);
    if (!bus.o_valid) check({name, "_valid_timeout"}, 32'(bus.o_valid), 32'd1);
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c;
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b0;
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_op    = OP_MUL;
    bus.i_dataA = '0;
    bus.i_dataB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   32'(bus.o_busy),  32'd0);
    check("reset_stall",  32'(bus.o_stall), 32'd0);
    check("reset_valid",  32'(bus.o_valid), 32'd0);
    check("reset_result", bus.o_result,     32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases; consecutive calls are back-to-back from IDLE.
    run_op(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, "mul_7x-3");
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff");
    run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ff");
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, "mulhsu");
    run_op(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, "div_-7_2");
    run_op(OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, "rem_-7_2");
    run_op(OP_DIVU,   32'd100,       32'd7,         "divu_100_7");
    run_op(OP_REMU,   32'd100,       32'd7,         "remu_100_7");
    run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(OP_DIVU,   32'd5,         32'd0,         "divu_by0");
    run_op(OP_REMU,   32'd5,         32'd0,         "remu_by0");
    run_op(OP_DIV,    32'hFFFF_FFF9, 32'd0,         "div_neg_by0");
    run_op(OP_REM,    32'hFFFF_FFF9, 32'd0,         "rem_neg_by0");
    run_op(OP_MULH,   32'd0,         32'h1234_5678, "mulh_zero");

    // Flush in CALC cycle 10: back to IDLE, no result.
    bus.i_op = OP_MUL; bus.i_dataA = 32'd3; bus.i_dataB = 32'd4; bus.i_start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.i_flush = 1'b1;
    bus.i_start = 1'b0;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    @(negedge clk);
    check("flush_busy",  32'(bus.o_busy),  32'd0);
    check("flush_stall", 32'(bus.o_stall), 32'd0);
    check("flush_valid", 32'(bus.o_valid), 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Flush together with start in IDLE: nothing is accepted.
    bus.i_start = 1'b1;
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk);
    #1;

    // Async reset in CALC cycle 5, then a clean restart.
    bus.i_op = OP_DIVU; bus.i_dataA = 32'd1000; bus.i_dataB = 32'd3; bus.i_start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(bus.o_busy), 32'd1);
    rst = 1'b0;
    #1;
    check("midreset_busy",   32'(bus.o_busy),  32'd0);
    check("midreset_stall",  32'(bus.o_stall), 32'd0);
    check("midreset_valid",  32'(bus.o_valid), 32'd0);
    check("midreset_result", bus.o_result,     32'd0);
    bus.i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_op(OP_DIVU, 32'd1000, 32'd3, "restart_divu");

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      mdu_op_e op;
      op = mdu_op_e'($urandom_range(0, 7));
      run_op(op, pick_operand(), pick_operand(), $sformatf("rand%0d_%s", i, op.name()));
      if ($urandom_range(0, 3) == 0) begin
        c = int'($urandom_range(1, 3));
        repeat (c) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
